// File: rtl/drawbridge_pkg.sv
// Shared types and constants for the drawbridge lift sequencer.
// State encodings are fixed 3-bit values so the debug port is stable.
package drawbridge_pkg;

  localparam int   TMR_W = 8;
  localparam logic ON    = 1'b1;
  localparam logic OFF   = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARN    = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_RAISE   = 3'd3,
    ST_OPEN    = 3'd4,
    ST_LOWER   = 3'd5,
    ST_RELEASE = 3'd6,
    ST_FAULT   = 3'd7
  } state_e;

endpackage

// File: rtl/car_occupancy_counter.sv
// Saturating up/down counter of cars currently on the deck.
// Simultaneous enter and leave pulses cancel out.
module car_occupancy_counter #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_hasCar
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc && !i_dec) begin
      if (r_count != '1) r_count <= r_count + CNT_W'(1);
    end else if (i_dec && !i_inc) begin
      if (r_count != '0) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_hasCar = |r_count;

endmodule

// File: rtl/drawbridge_lift_sequencer.sv
// Lift cycle sequencer: warn, barrier, deck clear, raise, hold, lower, release.
// Outputs are registered and decoded from the next state.
module drawbridge_lift_sequencer
  import drawbridge_pkg::*;
#(
  parameter int CNT_W          = 4,
  parameter int WARN_CYCLES    = 16,
  parameter int CLEAR_TIMEOUT  = 255,
  parameter int MOTION_TIMEOUT = 64,
  parameter int HOLD_CYCLES    = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_carIn,
  input  logic             i_carOut,
  input  logic             i_boatClose,
  input  logic             i_boatHere,
  input  logic             i_bridgeUp,
  input  logic             i_bridgeDown,
  input  logic             i_faultClr,
  output logic             o_carBarrier,
  output logic             o_alert,
  output logic             o_motorUp,
  output logic             o_motorDown,
  output logic             o_bridge_s,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_carCount,
  output logic [2:0]       o_state
);

  state_e           r_state;
  state_e           w_ns;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_load;
  logic             w_boatReq;
  logic             w_exp;
  logic             w_reload;
  logic             w_hasCar;
  logic [CNT_W-1:0] w_count;
  logic             r_barrier;
  logic             r_alert;
  logic             r_motorUp;
  logic             r_motorDown;
  logic             r_bridge_s;
  logic             r_fault;

  car_occupancy_counter #(.CNT_W(CNT_W)) u_cnt (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_inc    (i_carIn),
    .i_dec    (i_carOut),
    .o_count  (w_count),
    .o_hasCar (w_hasCar)
  );

  assign w_boatReq = i_boatClose | i_boatHere;
  assign w_exp     = (r_timer == '0);

  always_comb begin
    w_ns = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (!i_bridgeDown)  w_ns = ST_LOWER;
        else if (w_boatReq) w_ns = ST_WARN;
      end
      ST_WARN:
        if (w_exp) w_ns = ST_CLEAR;
      ST_CLEAR: begin
        if (!w_hasCar)  w_ns = ST_RAISE;
        else if (w_exp) w_ns = ST_FAULT;
      end
      ST_RAISE: begin
        if (i_bridgeUp) w_ns = ST_OPEN;
        else if (w_exp) w_ns = ST_FAULT;
      end
      ST_OPEN:
        if (!w_boatReq && w_exp) w_ns = ST_LOWER;
      ST_LOWER: begin
        if (i_bridgeDown)   w_ns = ST_RELEASE;
        else if (w_boatReq) w_ns = ST_RAISE;
        else if (w_exp)     w_ns = ST_FAULT;
      end
      ST_RELEASE:
        w_ns = ST_IDLE;
      ST_FAULT:
        if (i_faultClr && i_bridgeDown) w_ns = ST_IDLE;
      default:
        w_ns = ST_IDLE;
    endcase
    // Contradictory limit switches override everything
    if (i_bridgeUp && i_bridgeDown) w_ns = ST_FAULT;
  end

  always_comb begin
    w_load = '0;
    unique case (w_ns)
      ST_WARN:  w_load = TMR_W'(WARN_CYCLES - 1);
      ST_CLEAR: w_load = TMR_W'(CLEAR_TIMEOUT - 1);
      ST_RAISE: w_load = TMR_W'(MOTION_TIMEOUT - 1);
      ST_LOWER: w_load = TMR_W'(MOTION_TIMEOUT - 1);
      ST_OPEN:  w_load = TMR_W'(HOLD_CYCLES - 1);
      default:  w_load = '0;
    endcase
  end

  assign w_reload = (w_ns != r_state) ||
                    (r_state == ST_OPEN && w_boatReq);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_barrier   <= OFF;
      r_alert     <= OFF;
      r_motorUp   <= OFF;
      r_motorDown <= OFF;
      r_bridge_s  <= OFF;
      r_fault     <= OFF;
    end else begin
      r_state <= w_ns;
      if (w_reload)           r_timer <= w_load;
      else if (r_timer != '0) r_timer <= r_timer - TMR_W'(1);
      r_barrier <= (w_ns != ST_IDLE) && (w_ns != ST_WARN);
      r_alert   <= (w_ns != ST_IDLE) && (w_ns != ST_RELEASE);
      // A motor may only start once the opposite one was off last cycle
      r_motorUp   <= (w_ns == ST_RAISE) && !r_motorDown;
      r_motorDown <= (w_ns == ST_LOWER) && !r_motorUp;
      r_bridge_s  <= !i_bridgeDown || (w_ns == ST_RAISE) ||
                     (w_ns == ST_OPEN) || (w_ns == ST_LOWER);
      r_fault     <= (w_ns == ST_FAULT);
    end
  end

  assign o_carBarrier = r_barrier;
  assign o_alert      = r_alert;
  assign o_motorUp    = r_motorUp;
  assign o_motorDown  = r_motorDown;
  assign o_bridge_s   = r_bridge_s;
  assign o_fault      = r_fault;
  assign o_carCount   = w_count;
  assign o_state      = r_state;

endmodule

// File: tb/tb_drawbridge_lift_sequencer.sv
// Directed self-checking bench for drawbridge_lift_sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_drawbridge_lift_sequencer;

  logic       clk = 1'b0;
  logic       reset, carIn, carOut, boatClose, boatHere;
  logic       bridgeUp, bridgeDown, faultClr;
  logic       barrier, alert, motorUp, motorDown, bridge_s, fault;
  logic [3:0] carCount;
  logic [2:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  drawbridge_lift_sequencer dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_carIn      (carIn),
    .i_carOut     (carOut),
    .i_boatClose  (boatClose),
    .i_boatHere   (boatHere),
    .i_bridgeUp   (bridgeUp),
    .i_bridgeDown (bridgeDown),
    .i_faultClr   (faultClr),
    .o_carBarrier (barrier),
    .o_alert      (alert),
    .o_motorUp    (motorUp),
    .o_motorDown  (motorDown),
    .o_bridge_s   (bridge_s),
    .o_fault      (fault),
    .o_carCount   (carCount),
    .o_state      (state)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // state, barrier, alert, motorUp, motorDown
  task automatic outs(input string tag, input logic [2:0] s,
                      input logic b, input logic a,
                      input logic u, input logic d);
    check({tag, ".state"},   32'(state),     32'(s));
    check({tag, ".barrier"}, 32'(barrier),   32'(b));
    check({tag, ".alert"},   32'(alert),     32'(a));
    check({tag, ".up"},      32'(motorUp),   32'(u));
    check({tag, ".down"},    32'(motorDown), 32'(d));
  endtask

  initial begin
    reset = 1; carIn = 0; carOut = 0; boatClose = 0; boatHere = 0;
    bridgeUp = 0; bridgeDown = 1; faultClr = 0;
    step(2);
    outs("rst", 3'd0, 0, 0, 0, 0);
    check("rst.cnt",   32'(carCount), 0);
    check("rst.fault", 32'(fault),    0);
    check("rst.bs",    32'(bridge_s), 0);

    // 1 nominal lift cycle
    reset = 0; boatClose = 1;
    step(1);
    outs("t1.warn", 3'd1, 0, 1, 0, 0);
    step(15);
    outs("t1.warn16", 3'd1, 0, 1, 0, 0);
    step(1);
    outs("t1.clear", 3'd2, 1, 1, 0, 0);
    step(1);
    outs("t1.raise", 3'd3, 1, 1, 1, 0);
    check("t1.bs", 32'(bridge_s), 1);
    bridgeDown = 0;
    step(3);
    bridgeUp = 1;
    step(1);
    outs("t1.open", 3'd4, 1, 1, 0, 0);
    boatClose = 0;
    step(7);
    check("t1.hold7", 32'(state), 4);
    step(1);
    outs("t1.lower", 3'd5, 1, 1, 0, 1);
    bridgeUp = 0;
    step(2);
    bridgeDown = 1;
    step(1);
    outs("t1.release", 3'd6, 1, 0, 0, 0);
    check("t1.rel.bs", 32'(bridge_s), 0);
    step(1);
    outs("t1.idle", 3'd0, 0, 0, 0, 0);

    // 2 cars on deck hold the sequence in CLEAR
    for (int i = 0; i < 3; i++) begin
      carIn = 1; step(1); carIn = 0; step(1);
    end
    check("t2.cnt3", 32'(carCount), 3);
    boatHere = 1;
    step(17);
    outs("t2.clear", 3'd2, 1, 1, 0, 0);
    step(5);
    check("t2.wait", 32'(state), 2);
    for (int i = 0; i < 3; i++) begin
      carOut = 1; step(1); carOut = 0; step(1);
      if (i == 1) check("t2.cars1", 32'(state), 2);
    end
    outs("t2.raise", 3'd3, 1, 1, 1, 0);
    check("t2.cnt0", 32'(carCount), 0);

    // 3 raise timeout, fault clear needs bridge down
    bridgeDown = 0;
    step(63);
    check("t3.raise63", 32'(state), 3);
    step(1);
    outs("t3.fault", 3'd7, 1, 1, 0, 0);
    check("t3.flag", 32'(fault), 1);
    boatHere = 0; faultClr = 1;
    step(1);
    check("t3.clrIgn", 32'(state), 7);
    bridgeDown = 1;
    step(1);
    faultClr = 0;
    check("t3.idle", 32'(state), 0);
    check("t3.flag0", 32'(fault), 0);

    // 4 counter saturation and cancelling pulses
    carIn = 1;
    step(16);
    check("t4.sat15", 32'(carCount), 15);
    carOut = 1;
    step(1);
    check("t4.both", 32'(carCount), 15);
    carIn = 0;
    step(1);
    check("t4.dec", 32'(carCount), 14);
    step(16);
    carOut = 0;
    check("t4.floor", 32'(carCount), 0);
    check("t4.noflt", 32'(fault), 0);

    // 5 boat returns while lowering
    boatClose = 1;
    step(18);
    check("t5.raise", 32'(state), 3);
    bridgeDown = 0; bridgeUp = 1;
    step(1);
    boatClose = 0;
    step(8);
    outs("t5.lower", 3'd5, 1, 1, 0, 1);
    bridgeUp = 0;
    step(2);
    boatClose = 1;
    step(1);
    outs("t5.gap", 3'd3, 1, 1, 0, 0);
    step(1);
    outs("t5.up", 3'd3, 1, 1, 1, 0);

    // 6 reset with the bridge up, then sensor conflict
    bridgeUp = 1;
    step(1);
    check("t6.open", 32'(state), 4);
    reset = 1; boatClose = 0;
    step(1);
    outs("t6.rst", 3'd0, 0, 0, 0, 0);
    reset = 0;
    step(1);
    outs("t6.lower", 3'd5, 1, 1, 0, 1);
    check("t6.bs", 32'(bridge_s), 1);
    bridgeDown = 1;
    step(1);
    outs("t6.conf", 3'd7, 1, 1, 0, 0);
    check("t6.flag", 32'(fault), 1);
    bridgeUp = 0; faultClr = 1;
    step(1);
    faultClr = 0;
    check("t6.idle", 32'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
